i2c_shift_engine: RTL
=====================

I2C_SHIFT_ENGINE -- requirements
Module: i2c_shift_engine

Interface
REQ-001 Parameter WIDTH, default 8: shift register width in bits, legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = shift toward MSB and transmit bit WIDTH-1 first; 0 = shift toward LSB and transmit bit 0 first.
REQ-003 Port Clock, input, 1: single system clock; all state updates on its rising edge.
REQ-004 Port Reset, input, 1: synchronous, active-high reset.
REQ-005 Port SentData, input, WIDTH: parallel word to transmit.
REQ-006 Port WriteLoad, input, 1: parallel-load strobe, honoured only in IDLE.
REQ-007 Port Start, input, 1: begin a WIDTH-bit frame, honoured only in IDLE.
REQ-008 Port BitTick, input, 1: one-cycle strobe, one per serial bit (driven by the bus-timing block).
REQ-009 Port ShiftIn, input, 1: serial receive bit, sampled on BitTick.
REQ-010 Port RecData, output, WIDTH: register contents and received word.
REQ-011 Port ShiftOut, output, 1: current transmit bit.
REQ-012 Port Busy, output, 1: high in SHIFT state.
REQ-013 Port Done, output, 1: registered one-cycle completion pulse.
REQ-014 Port BitCount, output, $clog2(WIDTH+1): bits shifted in the current or last frame.

Function
REQ-015 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-016 In IDLE, WriteLoad=1 SHALL load RecData<=SentData on that edge.
REQ-017 In IDLE, Start=1 SHALL enter SHIFT and clear BitCount to 0 on that edge.
REQ-018 WriteLoad and Start asserted together in IDLE SHALL both take effect: load, then the frame transmits the loaded word.
REQ-019 In SHIFT, with BitTick=1 and MSB_FIRST=1, RecData SHALL become {RecData[WIDTH-2:0], ShiftIn}.
REQ-020 In SHIFT, with BitTick=1 and MSB_FIRST=0, RecData SHALL become {ShiftIn, RecData[WIDTH-1:1]}.
REQ-021 Each BitTick in SHIFT SHALL increment BitCount by 1.
REQ-022 With BitTick=0, RecData and BitCount SHALL hold.
REQ-023 The BitTick that increments BitCount to WIDTH SHALL also move the FSM to DONE.
REQ-024 In DONE, Done SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE on the next edge.
REQ-025 In DONE, RecData SHALL hold the received word and BitCount SHALL equal WIDTH; both SHALL hold through IDLE until the next load or start.
REQ-026 WriteLoad and Start SHALL be ignored in SHIFT and DONE; no queuing.
REQ-027 BitTick SHALL be ignored in IDLE and DONE.
REQ-028 ShiftOut SHALL be combinational: RecData[WIDTH-1] if MSB_FIRST=1, else RecData[0].
REQ-029 Busy SHALL be combinational: (state==SHIFT).
REQ-030 Minimum frame latency SHALL be WIDTH+1 cycles from Start to Done, with BitTick held high continuously.
REQ-031 BitCount SHALL never exceed WIDTH; it SHALL not wrap.

Reset
REQ-032 Reset=1 SHALL force state IDLE, RecData=0, BitCount=0, Done=0 on the next edge, overriding all other inputs.
REQ-033 Reset asserted mid-frame SHALL abort the frame without a Done pulse.
REQ-034 After reset, ShiftOut=0 and Busy=0.

Verification
REQ-035 WIDTH=8, MSB_FIRST=1: load 0xA5, Start, 8 BitTicks with ShiftIn=1,0,1,1,0,0,1,0 -> ShiftOut sequence 1,0,1,0,0,1,0,1; RecData=0xB2; one Done pulse; BitCount=8.
REQ-036 WIDTH=8, MSB_FIRST=0: load 0x01, Start, 8 BitTicks with ShiftIn=1 -> first ShiftOut=1, then 0s; RecData=0xFF; Done pulses once.
REQ-037 BitTick gaps: Start, then 8 BitTicks spaced 3 cycles apart -> RecData changes only on tick cycles; Busy high throughout; Done arrives 1 cycle after the 8th tick.
REQ-038 Ignored inputs: WriteLoad=1 with SentData=0x55, and Start=1, both mid-frame -> frame result unchanged; no restart; exactly one Done.
REQ-039 Reset after 4 BitTicks -> next cycle RecData=0, BitCount=0, Busy=0; Done never asserts.
REQ-040 WIDTH=16, MSB_FIRST=1: load 0x8001, Start, 16 ticks with ShiftIn=0 -> ShiftOut 1, fourteen 0s, 1; RecData=0x0000; BitCount=16.

Source files
------------

// File: rtl/i2c_shift_engine.sv
`default_nettype none
// ============================================================================
// Module      : i2c_shift_engine
// Description : Parallel-load / serial-shift engine for one I2C data frame.
//               Transmits the loaded word and captures the received word in
//               the same register, one bit per BitTick.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_shift_engine #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic [WIDTH-1:0]             SentData,
    input  logic                         WriteLoad,
    input  logic                         Start,
    input  logic                         BitTick,
    input  logic                         ShiftIn,
    output logic [WIDTH-1:0]             RecData,
    output logic                         ShiftOut,
    output logic                         Busy,
    output logic                         Done,
    output logic [$clog2(WIDTH+1)-1:0]   BitCount
);

    localparam int               c_CW       = $clog2(WIDTH + 1);
    localparam logic [c_CW-1:0]  c_LAST_BIT = c_CW'(WIDTH - 1);
    localparam logic [c_CW-1:0]  c_ONE      = c_CW'(1);

    localparam logic [1:0] c_STATE_IDLE  = 2'd0;
    localparam logic [1:0] c_STATE_SHIFT = 2'd1;
    localparam logic [1:0] c_STATE_DONE  = 2'd2;

    logic [1:0]        r_state;
    logic [WIDTH-1:0]  r_recData;
    logic [c_CW-1:0]   r_bitCount;
    logic              r_done;

    logic [1:0]        w_nextState;
    logic [WIDTH-1:0]  w_nextRecData;
    logic [c_CW-1:0]   w_nextBitCount;
    logic              w_nextDone;
    logic [WIDTH-1:0]  w_shifted;
    logic              w_txBit;

    // The same register serves as transmit source and receive sink: each tick
    // pushes the outgoing bit off one end and the sampled bit in at the other.
    generate
        if (MSB_FIRST != 0) begin : g_msbFirst
            assign w_shifted = {r_recData[WIDTH-2:0], ShiftIn};
            assign w_txBit   = r_recData[WIDTH-1];
        end else begin : g_lsbFirst
            assign w_shifted = {ShiftIn, r_recData[WIDTH-1:1]};
            assign w_txBit   = r_recData[0];
        end
    endgenerate

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state    <= c_STATE_IDLE;
            r_recData  <= '0;
            r_bitCount <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_recData  <= w_nextRecData;
            r_bitCount <= w_nextBitCount;
            r_done     <= w_nextDone;
        end
    end

    always_comb begin
        w_nextState    = r_state;
        w_nextRecData  = r_recData;
        w_nextBitCount = r_bitCount;
        w_nextDone     = 1'b0;
        case (r_state)
            c_STATE_IDLE: begin
                // Load and start on the same edge: the frame sends the new word.
                if (WriteLoad) begin
                    w_nextRecData = SentData;
                end
                if (Start) begin
                    w_nextState    = c_STATE_SHIFT;
                    w_nextBitCount = '0;
                end
            end
            c_STATE_SHIFT: begin
                if (BitTick) begin
                    w_nextRecData  = w_shifted;
                    w_nextBitCount = r_bitCount + c_ONE;
                    if (r_bitCount == c_LAST_BIT) begin
                        w_nextState = c_STATE_DONE;
                        w_nextDone  = 1'b1;
                    end
                end
            end
            c_STATE_DONE: begin
                w_nextState = c_STATE_IDLE;
            end
            default: begin
                w_nextState = c_STATE_IDLE;
            end
        endcase
    end

    assign RecData  = r_recData;
    assign BitCount = r_bitCount;
    assign Done     = r_done;
    assign ShiftOut = w_txBit;
    assign Busy     = (r_state == c_STATE_SHIFT);

endmodule
`default_nettype wire
